// File: rtl/gates_tester.sv
// Exhaustive tester for a seven-gate logic block: walks {a,b} through all
// four combinations, checks every gate result, and reports mismatch statistics.
module gates_tester #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic       a_o,
    output logic       b_o,
    input  logic       not_i,
    input  logic       and_i,
    input  logic       nand_i,
    input  logic       nor_i,
    input  logic       or_i,
    input  logic       xor_i,
    input  logic       xnor_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [4:0] err_cnt_o,
    output logic [6:0] err_vec_o,
    output logic [1:0] first_fail_o
);

    localparam int unsigned NGATES  = 7;
    localparam int unsigned SET_W   = 4;
    localparam int unsigned ERR_W   = 5;
    localparam int unsigned MCNT_W  = 3;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [NGATES-1:0]  err_vec_q, err_vec_d;
    logic [1:0]         first_fail_q, first_fail_d;

    logic [NGATES-1:0]  expect_c;
    logic [NGATES-1:0]  observe_c;
    logic [NGATES-1:0]  mism_c;
    logic [MCNT_W-1:0]  mism_cnt_c;

    // Reference gate values for the vector currently on a_o/b_o
    always_comb begin
        expect_c   = {~(a_q ^ b_q), a_q ^ b_q, a_q | b_q, ~(a_q | b_q),
                      ~(a_q & b_q), a_q & b_q, ~a_q};
        observe_c  = {xnor_i, xor_i, or_i, nor_i, nand_i, and_i, not_i};
        mism_c     = observe_c ^ expect_c;
        mism_cnt_c = '0;
        for (int i = 0; i < int'(NGATES); i++) begin
            mism_cnt_c = mism_cnt_c + MCNT_W'(mism_c[i]);
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        settle_d     = settle_q;
        a_d          = a_q;
        b_d          = b_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_cnt_d    = err_cnt_q;
        err_vec_d    = err_vec_q;
        first_fail_d = first_fail_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d      = S_DRIVE;
                    idx_d        = 2'd0;
                    settle_d     = '0;
                    a_d          = 1'b0;
                    b_d          = 1'b0;
                    busy_d       = 1'b1;
                    err_cnt_d    = '0;
                    err_vec_d    = '0;
                    first_fail_d = 2'b00;
                end
            end

            S_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = S_CHECK;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end

            S_CHECK: begin
                // Max 7 per check over 4 checks = 28, so no saturation is needed
                err_cnt_d = err_cnt_q + ERR_W'(mism_cnt_c);
                err_vec_d = err_vec_q | mism_c;
                // A zero running count means no earlier vector has failed
                if ((|mism_c) && (err_cnt_q == '0)) begin
                    first_fail_d = {a_q, b_q};
                end
                if (idx_q == 2'd3) begin
                    state_d = S_DONE;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    state_d    = S_DRIVE;
                    idx_d      = idx_q + 2'd1;
                    {a_d, b_d} = idx_q + 2'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            idx_q        <= 2'd0;
            settle_q     <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            err_vec_q    <= '0;
            first_fail_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            settle_q     <= settle_d;
            a_q          <= a_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            err_vec_q    <= err_vec_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign a_o          = a_q;
    assign b_o          = b_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign err_cnt_o    = err_cnt_q;
    assign err_vec_o    = err_vec_q;
    assign first_fail_o = first_fail_q;

endmodule

// File: doc/gates_tester.md
GATES_TESTER -- requirements
Module: gates_tester

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 2, number of cycles each input vector is held before the outputs are sampled; legal range 1..15.
REQ-002 clk_i  input  1  the single clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 start_i  input  1  run request; sampled only in IDLE.
REQ-005 a_o, b_o  output  1 each  registered stimulus driven into the gate block's a_i/b_i.
REQ-006 not_i, and_i, nand_i, nor_i, or_i, xor_i, xnor_i  input  1 each  gate-block results under test.
REQ-007 busy_o  output  1  high while a run is in progress.
REQ-008 done_o  output  1  single-cycle pulse at the end of a run.
REQ-009 pass_o  output  1  result of the last completed run: 1 when zero mismatches.
REQ-010 err_cnt_o  output  5  total mismatching output bits in the last run, 0..28.
REQ-011 err_vec_o  output  7  sticky per-gate fail flags; bit order [0]not [1]and [2]nand [3]nor [4]or [5]xor [6]xnor.
REQ-012 first_fail_o  output  2  {a,b} of the first vector with any mismatch; valid only when pass_o=0.

Function
REQ-013 FSM states: IDLE, DRIVE, CHECK, DONE.
REQ-014 IDLE + start_i=1 at an edge -> DRIVE; vector index=0; a_o/b_o=00; busy_o=1; err_cnt_o, err_vec_o, first_fail_o cleared; pass_o held until DONE.
REQ-015 Vector order: index 0..3 drives {a_o,b_o} = 00, 01, 10, 11.
REQ-016 DRIVE lasts exactly SETTLE_CYCLES cycles (4-bit settle counter), then -> CHECK.
REQ-017 CHECK lasts one cycle; the seven inputs are compared against expected values not=~a, and=a&b, nand=~(a&b), nor=~(a|b), or=a|b, xor=a^b, xnor=~(a^b), computed from the a_o/b_o being driven.
REQ-018 Each mismatching bit increments err_cnt_o by 1 (up to 7 per CHECK) and sets its err_vec_o bit; set bits remain set until the next start.
REQ-019 On the first CHECK with any mismatch, first_fail_o captures the current {a_o,b_o}; later mismatches do not overwrite it.
REQ-020 CHECK with index<3 -> DRIVE with the index incremented and a_o/b_o updated on the same edge; CHECK with index=3 -> DONE.
REQ-021 DONE lasts one cycle: done_o=1, busy_o=0, pass_o=(err_cnt_o==0); then -> IDLE. a_o/b_o return to 00 on entry to DONE.
REQ-022 Run length: busy_o high for exactly 4*(SETTLE_CYCLES+1) cycles, followed immediately by the done_o cycle.
REQ-023 start_i is ignored in DRIVE, CHECK and DONE; if start_i is high in IDLE on the cycle after DONE, a new run begins.
REQ-024 err_cnt_o never wraps; its maximum reachable value is 28, which fits 5 bits.

Reset
REQ-025 rst_i=1 forces, asynchronously, state=IDLE, index=0, settle counter=0, a_o=b_o=0, busy_o=0, done_o=0, pass_o=0, err_cnt_o=0, err_vec_o=0, first_fail_o=0.
REQ-026 Reset asserted mid-run aborts the run with no done_o pulse; after rst_i falls, the block waits in IDLE for start_i.

Verification
REQ-027 Reset: assert rst_i between clock edges -> all outputs 0 immediately, before the next edge.
REQ-028 Correct gates model, SETTLE_CYCLES=2, one start_i pulse -> a_o/b_o = 00,01,10,11, each held 3 cycles; busy_o high 12 cycles; done_o high on cycle 13; pass_o=1, err_cnt_o=0, err_vec_o=0000000.
REQ-029 and_i stuck at 0 -> err_cnt_o=1, err_vec_o=0000010, first_fail_o=11, pass_o=0.
REQ-030 not_i stuck at 1 -> err_cnt_o=2, err_vec_o=0000001, first_fail_o=10, pass_o=0.
REQ-031 All seven inputs inverted -> err_cnt_o=28, err_vec_o=1111111, first_fail_o=00; start_i held high throughout -> extra starts ignored during the run, new run begins in the IDLE cycle after done_o.
REQ-032 rst_i pulsed during vector 01 -> outputs cleared, no done_o pulse; a following start gives a clean full run with the REQ-028 results.
